// File: rtl/pe_pkg.sv
// Shared Q2.13 definitions for the systolic PE: widths, the product slice rule
// and the controller state encoding.
package pe_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 13;
  localparam int PROD_W = 2 * DATA_W;

  typedef logic signed [DATA_W-1:0] q_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_ADD,
    ST_OUT,
    ST_ARM
  } state_t;

  // Drop the 13 fraction bits and the top integer bits, keeping the sign:
  // truncates toward minus infinity and wraps on overflow.
  function automatic q_t q_slice(input prod_t p);
    return {p[PROD_W-1], p[FRAC_W+DATA_W-2:FRAC_W]};
  endfunction

endpackage

// File: rtl/pe_qmul.sv
// Combinational signed Q2.13 multiply, returning the product already sliced
// back to Q2.13.
module pe_qmul
  import pe_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] q
);

  // Both operands are sign-extended to full product width before multiplying.
  assign q = q_slice(prod_t'(a) * prod_t'(b));

endmodule

// File: rtl/pe.sv
// Multiply-accumulate processing element: O_OUT = D + X*W in Q2.13, with
// X forwarded to the right-hand neighbour one cycle later.
module pe
  import pe_pkg::*;
(
  input  logic                     I_CLK,
  input  logic                     I_RST,
  input  logic                     I_X_VLD,
  input  logic signed [DATA_W-1:0] I_X,
  input  logic                     I_W_VLD,
  input  logic signed [DATA_W-1:0] I_W,
  input  logic                     I_D_VLD,
  input  logic signed [DATA_W-1:0] I_D,
  output logic                     O_X_VLD,
  output logic signed [DATA_W-1:0] O_X,
  output logic                     O_MUL_DONE,
  output logic                     O_OUT_VLD,
  output logic signed [DATA_W-1:0] O_OUT
);

  state_t state_reg;
  state_t state_next;

  q_t   x_reg;
  q_t   w_reg;
  q_t   d_reg;
  q_t   p_reg;
  q_t   p_next;
  q_t   out_reg;
  q_t   ox_reg;
  logic ox_vld_reg;
  logic all_vld;
  logic mul_done;
  logic out_vld;

  assign all_vld = I_X_VLD & I_W_VLD & I_D_VLD;

  // The slice only looks at product bits, so registering the sliced value
  // is equivalent to registering the full product.
  pe_qmul u_qmul (
    .a (x_reg),
    .b (w_reg),
    .q (p_next)
  );

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (all_vld) state_next = ST_MUL;
      ST_MUL:  state_next = ST_ADD;
      ST_ADD:  state_next = ST_OUT;
      ST_OUT:  state_next = ST_ARM;
      ST_ARM:  if (!all_vld) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mul_done = 1'b0;
    out_vld  = 1'b0;
    case (state_reg)
      ST_ADD:  mul_done = 1'b1;
      ST_OUT:  out_vld  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      x_reg      <= '0;
      w_reg      <= '0;
      d_reg      <= '0;
      p_reg      <= '0;
      out_reg    <= '0;
      ox_reg     <= '0;
      ox_vld_reg <= 1'b0;
    end else begin
      ox_reg     <= I_X;
      ox_vld_reg <= I_X_VLD;
      if (state_reg == ST_IDLE && all_vld) begin
        x_reg <= I_X;
        w_reg <= I_W;
        d_reg <= I_D;
      end
      if (state_reg == ST_MUL) begin
        p_reg <= p_next;
      end
      // Plain 16-bit add: overflow wraps rather than saturating.
      if (state_reg == ST_ADD) begin
        out_reg <= p_reg + d_reg;
      end
    end
  end

  assign O_X        = ox_reg;
  assign O_X_VLD    = ox_vld_reg;
  assign O_MUL_DONE = mul_done;
  assign O_OUT_VLD  = out_vld;
  assign O_OUT      = out_reg;

endmodule

// File: tb/tb_pe.sv
// Self-checking bench for pe: directed Q2.13 vectors, random operands against
// an arithmetic reference, reset abort and X forwarding.
module tb_pe;

  logic        clk = 1'b0;
  logic        rst;
  logic        x_vld, w_vld, d_vld;
  logic [15:0] x, w, d;
  logic        o_x_vld, o_mul_done, o_out_vld;
  logic [15:0] o_x, o_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pe dut (
    .I_CLK      (clk),
    .I_RST      (rst),
    .I_X_VLD    (x_vld),
    .I_X        (x),
    .I_W_VLD    (w_vld),
    .I_W        (w),
    .I_D_VLD    (d_vld),
    .I_D        (d),
    .O_X_VLD    (o_x_vld),
    .O_X        (o_x),
    .O_MUL_DONE (o_mul_done),
    .O_OUT_VLD  (o_out_vld),
    .O_OUT      (o_out)
  );

  // Reference: exact integer product, floor-divide by 2^13, keep 15 bits
  // plus the product sign, then a modulo-2^16 add of D.
  function automatic logic [15:0] ref_mac(input logic [15:0] xv, input logic [15:0] wv,
                                          input logic [15:0] dv);
    longint p;
    longint s;
    logic [63:0] r;
    p = longint'($signed(xv)) * longint'($signed(wv));
    s = (p >>> 13) & 64'h7FFF;
    if (p < 0) s = s + 32768;
    r = 64'(s + longint'($signed(dv)));
    return r[15:0];
  endfunction

  // Drives one operation from a negedge in IDLE and checks pulse timing and
  // result; leaves the PE back in IDLE at a negedge.
  task automatic run_op(input string name, input logic [15:0] xv, input logic [15:0] wv,
                        input logic [15:0] dv, input bit hold);
    logic [15:0] exp;
    int          drop;
    exp = ref_mac(xv, wv, dv);
    x = xv; w = wv; d = dv;
    x_vld = 1'b1; w_vld = 1'b1; d_vld = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (!hold) begin
        x = 16'($urandom); w = 16'($urandom); d = 16'($urandom);
      end
      n_tests++;
      if (o_mul_done !== (c == 2)) begin
        n_fail++;
        $display("FAIL %s mul_done cycle %0d: got %b want %b", name, c, o_mul_done, (c == 2));
      end
      n_tests++;
      if (o_out_vld !== (c == 3)) begin
        n_fail++;
        $display("FAIL %s out_vld cycle %0d: got %b want %b", name, c, o_out_vld, (c == 3));
      end
      if (c >= 3) begin
        n_tests++;
        if (o_out !== exp) begin
          n_fail++;
          $display("FAIL %s out cycle %0d: x=%h w=%h d=%h got %h want %h",
                   name, c, xv, wv, dv, o_out, exp);
        end
      end
    end
    if (hold) begin
      for (int c = 5; c <= 9; c++) begin
        @(negedge clk);
        n_tests++;
        if (o_out_vld !== 1'b0 || o_mul_done !== 1'b0) begin
          n_fail++;
          $display("FAIL %s retrigger cycle %0d: out_vld=%b mul_done=%b want 0/0",
                   name, c, o_out_vld, o_mul_done);
        end
      end
    end
    drop = $urandom_range(1, 7);
    x_vld = !drop[0]; w_vld = !drop[1]; d_vld = !drop[2];
    @(negedge clk);
    n_tests++;
    if (o_out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release out_vld: got %b want 0", name, o_out_vld);
    end
    $display("[TB] %s x=%h w=%h d=%h -> out=%h (expect %h)", name, xv, wv, dv, o_out, exp);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    x_vld = 1'b0; w_vld = 1'b0; d_vld = 1'b0;
    x = '0; w = '0; d = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_tests++;
      if (o_mul_done !== 1'b0 || o_out_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL reset pulses cycle %0d: mul_done=%b out_vld=%b want 0/0",
                 c, o_mul_done, o_out_vld);
      end
    end
    n_tests++;
    if ({o_x_vld, o_x, o_out} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset outputs: x_vld=%b x=%h out=%h want all 0", o_x_vld, o_x, o_out);
    end
    rst = 1'b0;
    $display("[TB] reset held 10 cycles");
  endtask

  task automatic test_directed();
    run_op("unit", 16'h2000, 16'h2000, 16'h0000, 1'b1);
    run_op("neg", 16'hE000, 16'h4000, 16'h1000, 1'b0);
    run_op("wrap", 16'h7FFF, 16'h7FFF, 16'h0010, 1'b1);
  endtask

  task automatic test_reset_abort();
    x = 16'h1234; w = 16'h2345; d = 16'h0101;
    x_vld = 1'b1; w_vld = 1'b1; d_vld = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    x_vld = 1'b0; w_vld = 1'b0; d_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      n_tests++;
      if (o_out_vld !== 1'b0 || o_mul_done !== 1'b0 || o_out !== 16'h0000) begin
        n_fail++;
        $display("FAIL abort cycle %0d: out_vld=%b mul_done=%b out=%h want 0/0/0000",
                 c, o_out_vld, o_mul_done, o_out);
      end
      @(negedge clk);
    end
    $display("[TB] reset abort mid-operation");
  endtask

  task automatic test_random();
    logic [15:0] xv, wv, dv;
    for (int i = 0; i < 1000; i++) begin
      xv = 16'($urandom); wv = 16'($urandom); dv = 16'($urandom);
      run_op("rand", xv, wv, dv, (i % 7) == 0);
    end
  endtask

  task automatic test_xfwd();
    logic [2:0]  pat;
    logic [15:0] px;
    logic        pv;
    pat = 3'b101;
    for (int i = 0; i < 30; i++) begin
      x = 16'($urandom); w = 16'($urandom); d = 16'($urandom);
      x_vld = pat[i % 3]; w_vld = 1'b1; d_vld = 1'b1;
      px = x; pv = x_vld;
      @(negedge clk);
      n_tests++;
      if (o_x !== px || o_x_vld !== pv) begin
        n_fail++;
        $display("FAIL xfwd step %0d: got x=%h vld=%b want x=%h vld=%b", i, o_x, o_x_vld, px, pv);
      end
      $display("[TB] xfwd step %0d x=%h vld=%b", i, o_x, o_x_vld);
    end
    x_vld = 1'b0; w_vld = 1'b0; d_vld = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_abort();
    test_random();
    test_xfwd();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
